// File: rtl/fir_deconvolver.sv
// fir_deconvolver: recovers x[n] from y[n] = sum h[k]*x[n-k] (h[0] = 1)
// by recursive deconvolution on a single time-multiplexed multiplier.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low (clears everything)
//   flush      synchronous clear of history/FSM, keeps sat
//   in_data    y[n], signed DW bits
//   in_valid   in_data valid
//   in_ready   high only while idle
//   out_data   x[n], signed, saturated to DW bits
//   out_valid  out_data valid, held until out_ready
//   out_ready  downstream accepts out_data
//   sat        sticky saturation flag, cleared only by rst
module fir_deconvolver #(
  parameter int N  = 5,
  parameter int DW = 16,
  parameter int AW = 40,
  parameter logic [N*DW-1:0] COEFFS =
    {16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat
);

  localparam int KW = (N > 2) ? $clog2(N) : 1;

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [KW-1:0] KLAST = KW'(N-1);

  if (N < 2) begin : g_bad_n
    $error("fir_deconvolver: N must be >= 2");
  end
  if (COEFFS[DW-1:0] != DW'(1)) begin : g_bad_h0
    $error("fir_deconvolver: h[0] must be 1");
  end
  if (AW < 2*DW) begin : g_bad_aw
    $error("fir_deconvolver: AW must be >= 2*DW");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t                 r_state;
  logic [KW-1:0]          r_k;
  logic signed [AW-1:0]   r_acc;
  // r_hist[i] holds x[n-1-i], i.e. hist[i+1]
  logic signed [DW-1:0]   r_hist [N-1];
  logic [DW-1:0]          r_out;
  logic                   r_valid;
  logic                   r_sat;

  logic signed [DW-1:0]   w_h;
  logic signed [DW-1:0]   w_x;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   w_prod_ext;
  logic signed [AW-1:0]   w_next;
  logic                   w_hi;
  logic                   w_lo;
  logic [DW-1:0]          w_res;
  logic signed [AW-1:0]   w_load;

  // Tap select: coefficient and history operand for the current k.
  always_comb begin
    w_h = '0;
    w_x = '0;
    for (int i = 1; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_h = COEFFS[i*DW +: DW];
        w_x = r_hist[i-1];
      end
    end
  end

  assign w_prod     = w_h * w_x;
  assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_next     = r_acc - w_prod_ext;

  assign w_hi  = (w_next > SMAX);
  assign w_lo  = (w_next < SMIN);
  assign w_res = w_hi ? SMAX[DW-1:0] :
                 w_lo ? SMIN[DW-1:0] :
                        w_next[DW-1:0];

  assign w_load = {{(AW-DW){in_data[DW-1]}}, in_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      for (int i = 0; i < N-1; i++) r_hist[i] <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < N-1; i++) r_hist[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc   <= w_load;
            r_k     <= KW'(1);
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc <= w_next;
          if (r_k == KLAST) begin
            // Last tap: the clamped value is both emitted and
            // fed back, so the history matches the output stream.
            r_out   <= w_res;
            r_valid <= 1'b1;
            if (w_hi || w_lo) r_sat <= 1'b1;
            r_hist[0] <= w_res;
            for (int i = 1; i < N-1; i++) r_hist[i] <= r_hist[i-1];
            r_state <= S_OUTPUT;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign sat       = r_sat;

endmodule

// File: tb/tb_fir_deconvolver.sv
// tb_fir_deconvolver: directed vector table plus hand-written
// sequences for back-pressure, mid-op flush/reset and latency.
module tb_fir_deconvolver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sat;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  fir_deconvolver dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                 clr;
    logic signed [15:0] y;
    logic signed [15:0] x;
    bit                 s;
  } vec_t;

  vec_t tbl [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One sample through with out_ready=1; returns output, latency,
  // acceptance cycle and a timeout flag.
  task automatic push(input logic [15:0] y, output logic [15:0] got,
                      output int lat, output int acc_cyc,
                      output bit to);
    int c;
    to = 0;
    c = 0;
    in_data = y;
    in_valid = 1'b1;
    while (!in_ready && c < 20) begin
      step();
      c++;
    end
    if (!in_ready) to = 1;
    step();
    acc_cyc = cyc;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) to = 1;
    got = out_data;
    step();
  endtask

  task automatic run_impulse(input string tag);
    logic [15:0] got;
    int lat, ac;
    bit to;
    logic signed [15:0] ys [8];
    ys = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd0, 16'sd0, 16'sd0};
    for (int i = 0; i < 8; i++) begin
      push(ys[i], got, lat, ac, to);
      check({tag, "_to"}, int'(to), 0);
      check({tag, "_x"}, int'($signed(got)), (i == 0) ? 1 : 0);
    end
  endtask

  initial begin
    logic [15:0] got;
    int lat, ac, prev_ac;
    bit to, seen;

    tbl[0]  = '{1'b1, 16'sd1,  16'sd1, 1'b0};
    tbl[1]  = '{1'b0, 16'sd2,  16'sd0, 1'b0};
    tbl[2]  = '{1'b0, 16'sd3,  16'sd0, 1'b0};
    tbl[3]  = '{1'b0, 16'sd4,  16'sd0, 1'b0};
    tbl[4]  = '{1'b0, 16'sd5,  16'sd0, 1'b0};
    tbl[5]  = '{1'b0, 16'sd0,  16'sd0, 1'b0};
    tbl[6]  = '{1'b0, 16'sd0,  16'sd0, 1'b0};
    tbl[7]  = '{1'b0, 16'sd0,  16'sd0, 1'b0};
    tbl[8]  = '{1'b1, 16'sd1,  16'sd1, 1'b0};
    tbl[9]  = '{1'b0, 16'sd4,  16'sd2, 1'b0};
    tbl[10] = '{1'b0, 16'sd10, 16'sd3, 1'b0};
    tbl[11] = '{1'b0, 16'sd16, 16'sd0, 1'b0};
    tbl[12] = '{1'b0, 16'sd22, 16'sd0, 1'b0};
    tbl[13] = '{1'b0, 16'sd22, 16'sd0, 1'b0};
    tbl[14] = '{1'b0, 16'sd15, 16'sd0, 1'b0};
    tbl[15] = '{1'b0, 16'sd0,  16'sd0, 1'b0};
    tbl[16] = '{1'b1, 16'h8000, 16'h8000, 1'b0};
    // raw 32767 + 2*32768 = 98303 clamps high
    tbl[17] = '{1'b0, 16'sd32767, 16'sd32767, 1'b1};
    // raw 0 - 2*32767 + 3*32768 = 32770 clamps high
    tbl[18] = '{1'b0, 16'sd0, 16'sd32767, 1'b1};

    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_in_ready", int'(in_ready), 1);

    prev_ac = -1;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].clr) begin
        do_reset();
        prev_ac = -1;
      end
      push(tbl[i].y, got, lat, ac, to);
      check($sformatf("v%0d_to", i), int'(to), 0);
      check($sformatf("v%0d_x", i), int'($signed(got)),
            int'(tbl[i].x));
      check($sformatf("v%0d_sat", i), int'(sat), int'(tbl[i].s));
      check($sformatf("v%0d_lat", i), lat, 4);
      if (prev_ac >= 0)
        check($sformatf("v%0d_gap", i), ac - prev_ac, 6);
      prev_ac = ac;
    end

    // Back-pressure: out held, input ignored for 10 cycles.
    do_reset();
    out_ready = 1'b0;
    in_data = 16'sd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) step();
    check("bp_valid", int'(out_valid), 1);
    for (int c = 0; c < 10; c++) begin
      in_data = 16'sd99;
      in_valid = c[0];
      step();
      check("bp_hold_data", int'($signed(out_data)), 7);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    step();
    step();
    check("bp_single_hs", int'(out_valid), 0);
    // 14 - 2*7 = 0 only if the ignored 99s never entered history
    push(16'sd14, got, lat, ac, to);
    check("bp_after_to", int'(to), 0);
    check("bp_after_x", int'($signed(got)), 0);

    // Flush mid-ACCUM keeps sat, clears history.
    do_reset();
    push(16'h8000, got, lat, ac, to);
    push(16'sd32767, got, lat, ac, to);
    check("fl_pre_sat", int'(sat), 1);
    in_data = 16'sd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("fl_no_valid", int'(seen), 0);
    check("fl_sat_kept", int'(sat), 1);
    check("fl_in_ready", int'(in_ready), 1);
    run_impulse("fl_imp");
    check("fl_sat_end", int'(sat), 1);

    // Reset mid-ACCUM clears sat as well.
    in_data = 16'sd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("rs_no_valid", int'(seen), 0);
    check("rs_sat_clr", int'(sat), 0);
    run_impulse("rs_imp");
    check("rs_sat_end", int'(sat), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
